// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared constants and types for the memory arbiter:
//            state encodings, grant encodings, default widths, and the
//            nominal memory latency.
// Ports    : none (package)
// Config   : MEM_ARB_RR_EN selects round-robin tie-breaking (see mem_arb_pick)
// Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int ADDR_W_DEF      = WORD_SIZE - 2;
  localparam int LINE_W_DEF      = CACHE_LINE_SIZE;

  localparam logic [1:0] MEM_ARB_IDLE    = 2'd0;
  localparam logic [1:0] MEM_ARB_BUSY    = 2'd1;
  localparam logic [1:0] MEM_ARB_RELEASE = 2'd2;

  localparam logic MEM_ARB_GRANT_IC = 1'b0;
  localparam logic MEM_ARB_GRANT_DC = 1'b1;

  // Cycles from the granting edge to the ready pulse.
  localparam int MEM_LATENCY = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = MEM_ARB_IDLE,
    ST_BUSY    = MEM_ARB_BUSY,
    ST_RELEASE = MEM_ARB_RELEASE
  } state_t;

  typedef enum logic {
    GRANT_IC = MEM_ARB_GRANT_IC,
    GRANT_DC = MEM_ARB_GRANT_DC
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the icache, dcache and memory-side signals of the arbiter.
// Modports : slave  - arbiter view (requests/memory returns in, grants out)
//            master - environment view (caches + memory)
// Signals  : ic_req/ic_addr/ic_ready/ic_line            icache port
//            dc_req/dc_we/dc_addr/dc_wline/dc_ready/dc_line  dcache port
//            mem_addr/mem_wline/mem_read/mem_write/mem_ready/mem_line  memory
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [LINE_W-1:0] ic_line;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wline;
  logic              dc_ready;
  logic [LINE_W-1:0] dc_line;

  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_line;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_ready, mem_line,
    output ic_ready, ic_line, dc_ready, dc_line, mem_addr, mem_wline, mem_read, mem_write
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_ready, mem_line,
    input  ic_ready, ic_line, dc_ready, dc_line, mem_addr, mem_wline, mem_read, mem_write
  );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational winner selection between icache and dcache.
// Ports    : ic_req, dc_req   in   pending requests
//            last_grant       in   requester served last (MEM_ARB_RR_EN only)
//            any_req          out  at least one request pending
//            winner           out  selected requester
// Config   : MEM_ARB_RR_EN defined   -> ties go to the requester not served last
//            MEM_ARB_RR_EN undefined -> fixed dcache-over-icache priority
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
`ifdef MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output logic   any_req,
  output grant_t winner
);

  always_comb begin
    any_req = ic_req | dc_req;
    winner  = GRANT_DC;
`ifdef MEM_ARB_RR_EN
    if (ic_req && dc_req) begin
      winner = (last_grant == GRANT_DC) ? GRANT_IC : GRANT_DC;
    end else if (ic_req) begin
      winner = GRANT_IC;
    end
`else
    if (ic_req && !dc_req) begin
      winner = GRANT_IC;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported line memory between the icache
//            (read-only) and the dcache (read/write). Latches the winner's
//            request, drives memory Read/Write until Ready, returns the line
//            with a one-cycle ready pulse, then idles the memory for one
//            RELEASE cycle so its delay chain clears.
// Ports    : clk   in   clock, all state on posedge
//            rst   in   synchronous active-high reset
//            bus   slave modport of mem_arbiter_if (cache + memory signals)
// Config   : MEM_ARB_RR_EN enables round-robin tie-breaking with a last-grant
//            register; otherwise dcache has fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
)(
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  state_t            state, state_nxt;
  grant_t            grant, grant_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wline_q, wline_nxt;
  logic              read_q, read_nxt;
  logic              write_q, write_nxt;

  logic              any_req;
  grant_t            winner;
  logic              load;

`ifdef MEM_ARB_RR_EN
  grant_t            last_grant;

  // Reset to dcache so the first tie after reset goes to the icache.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_DC;
    end else if (load) begin
      last_grant <= winner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .ic_req     (bus.ic_req),
    .dc_req     (bus.dc_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  // A new grant may start from IDLE or directly at the RELEASE exit edge.
  assign load = ((state == ST_IDLE) || (state == ST_RELEASE)) && any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= GRANT_IC;
      addr_q  <= '0;
      wline_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      addr_q  <= addr_nxt;
      wline_q <= wline_nxt;
      read_q  <= read_nxt;
      write_q <= write_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    addr_nxt  = addr_q;
    wline_nxt = wline_q;
    read_nxt  = read_q;
    write_nxt = write_q;

    case (state)
      ST_IDLE, ST_RELEASE: begin
        state_nxt = ST_IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        if (load) begin
          state_nxt = ST_BUSY;
          grant_nxt = winner;
          if (winner == GRANT_DC) begin
            addr_nxt  = bus.dc_addr;
            wline_nxt = bus.dc_wline;
            read_nxt  = ~bus.dc_we;
            write_nxt = bus.dc_we;
          end else begin
            addr_nxt  = bus.ic_addr;
            read_nxt  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (bus.mem_ready) begin
          state_nxt = ST_RELEASE;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wline = wline_q;
  assign bus.mem_read  = read_q;
  assign bus.mem_write = write_q;

  // Ready is only honoured in BUSY; a stale Ready in RELEASE/IDLE is ignored.
  assign bus.ic_ready  = (state == ST_BUSY) && (grant == GRANT_IC) && bus.mem_ready;
  assign bus.dc_ready  = (state == ST_BUSY) && (grant == GRANT_DC) && bus.mem_ready;
  assign bus.ic_line   = bus.mem_line;
  assign bus.dc_line   = bus.mem_line;

endmodule
`default_nettype wire
